fifo_read_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/fifo_read_arbiter_rr_pick.sv | 36 +++
 rtl/fifo_read_arbiter.sv | 136 +++++++++++++
 tb/tb_fifo_read_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for fifo_read_arbiter
// Contents: arbiter state enum, constant-foldable clog2, default burst length.

package fifo_arb_pkg;

  localparam int DEFAULT_BURST_LEN = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Ceiling log2 usable in parameter expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_rr_pick.sv
// rtl/fifo_read_arbiter_rr_pick.sv - round-robin first-requester search
// Ports:
//   req     in   N_CH  per-channel request (FIFO non-empty)
//   rr_ptr  in   CH_W  last granted channel; search starts at rr_ptr+1
//   found   out  1     some channel is requesting
//   index   out  CH_W  first requesting channel after rr_ptr (modulo N_CH)

module rr_pick #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] rr_ptr,
  output logic            found,
  output logic [CH_W-1:0] index
);

  always_comb begin
    int c;
    logic [CH_W-1:0] ci;
    found = 1'b0;
    index = '0;
    c     = 0;
    ci    = '0;
    // Offsets 1..N_CH so rr_ptr itself is visited last.
    for (int k = 1; k <= N_CH; k++) begin
      c  = (int'(rr_ptr) + k) % N_CH;
      ci = CH_W'(c);
      if (!found && req[ci]) begin
        found = 1'b1;
        index = ci;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// rtl/fifo_read_arbiter.sv - round-robin burst scheduler draining N FIFOs into one stream
// Optional feature macro: FIFO_ARB_WCOUNT_EN (adds word_cnt accepted-word counter).
// Ports:
//   rclk       in   1            read-domain clock
//   rrst       in   1            asynchronous active-high reset
//   in_rempty  in   N_CH         per-channel FIFO empty flag
//   in_rdata   in   N_CH*DATA_W  per-channel FIFO head word
//   in_rinc    out  N_CH         per-channel pop strobe (combinational, one-hot or zero)
//   out_valid  out  1            output word valid
//   out_ready  in   1            downstream accepts word
//   out_data   out  DATA_W       output word
//   out_chan   out  CH_W         source channel of out_data
//   out_last   out  1            word completes a full BURST_LEN burst
//   busy       out  1            a burst grant is active
//   word_cnt   out  32           accepted output words (only with FIFO_ARB_WCOUNT_EN)

module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = DEFAULT_BURST_LEN,
  parameter int CH_W      = 2
) (
  input  logic                     rclk,
  input  logic                     rrst,
  input  logic [N_CH-1:0]          in_rempty,
  input  logic [N_CH*DATA_W-1:0]   in_rdata,
  output logic [N_CH-1:0]          in_rinc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_chan,
  output logic                     out_last,
  output logic                     busy
`ifdef FIFO_ARB_WCOUNT_EN
  ,
  output logic [31:0]              word_cnt
`endif
);

  localparam int              CNT_W    = clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  arb_state_t       state;
  logic [CH_W-1:0]  sel;
  logic [CH_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] burst_cnt;

  logic             pick_found;
  logic [CH_W-1:0]  pick_idx;
  logic             can_load;
  logic             sel_empty;
  logic             pop;
  logic             last_pop;

  rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_rr_pick (
    .req    (~in_rempty),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .index  (pick_idx)
  );

  assign can_load  = !out_valid || out_ready;
  assign sel_empty = in_rempty[sel];
  // Same-cycle pop relies on the FIFO deasserting rempty on the pop edge.
  assign pop       = (state == BURST) && !sel_empty && can_load;
  assign last_pop  = pop && (burst_cnt == LAST_CNT);
  assign busy      = (state == BURST);

  always_comb begin
    in_rinc      = '0;
    in_rinc[sel] = pop;
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state     <= IDLE;
      sel       <= '0;
      rr_ptr    <= CH_W'(N_CH - 1);
      burst_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_last  <= 1'b0;
    end else begin
      // Output register: load on pop, retire an accepted word otherwise.
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= in_rdata[int'(sel)*DATA_W +: DATA_W];
        out_chan  <= sel;
        out_last  <= last_pop;
      end else if (can_load) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            sel       <= pick_idx;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (sel_empty) begin
            // Early termination: channel ran dry before a full burst.
            rr_ptr <= sel;
            state  <= IDLE;
          end else if (pop) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (last_pop) begin
              rr_ptr <= sel;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_WCOUNT_EN
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      word_cnt <= '0;
    end else if (out_valid && out_ready) begin
      word_cnt <= word_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb/tb_fifo_read_arbiter.sv - directed self-checking bench for fifo_read_arbiter

module tb_fifo_read_arbiter;

  logic        rclk;
  logic        rrst;
  logic [3:0]  in_rempty;
  logic [63:0] in_rdata;
  logic [3:0]  in_rinc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic        out_last;
  logic        busy;
`ifdef FIFO_ARB_WCOUNT_EN
  logic [31:0] word_cnt;
`endif

  int tests = 0;
  int fails = 0;

  fifo_read_arbiter #(
    .N_CH      (4),
    .DATA_W    (16),
    .BURST_LEN (8),
    .CH_W      (2)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .in_rempty (in_rempty),
    .in_rdata  (in_rdata),
    .in_rinc   (in_rinc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_last  (out_last),
    .busy      (busy)
`ifdef FIFO_ARB_WCOUNT_EN
    ,
    .word_cnt  (word_cnt)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // FIFO read-side model: pointer advances on the edge that sees in_rinc.
  logic [15:0] mem [4][256];
  logic [7:0]  rd  [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0]  wr  [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
  int          nxt [4] = '{0, 0, 0, 0};

  for (genvar g = 0; g < 4; g++) begin : g_fifo
    assign in_rempty[g]          = (rd[g] == wr[g]);
    assign in_rdata[g*16 +: 16]  = mem[g][rd[g]];
  end

  always @(posedge rclk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rrst && in_rinc[i]) rd[i] <= rd[i] + 8'd1;
    end
  end

  int cyc = 0;
  always @(posedge rclk) cyc <= cyc + 1;

  // Monitor at negedge: inputs/outputs are stable until the next posedge.
  logic [15:0] cap_data [$];
  logic [1:0]  cap_chan [$];
  logic        cap_last [$];
  int          cap_cyc  [$];
  int          viol_onehot    = 0;
  int          viol_stall     = 0;
  int          viol_stall_pop = 0;
  logic        prev_stall     = 1'b0;
  logic [19:0] prev_out       = '0;

  always @(negedge rclk) begin
    if (rrst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && ({out_valid, out_data, out_chan, out_last} !== prev_out))
        viol_stall <= viol_stall + 1;
      if (out_valid && !out_ready && in_rinc != 4'b0)
        viol_stall_pop <= viol_stall_pop + 1;
      if ($countones(in_rinc) > 1)
        viol_onehot <= viol_onehot + 1;
      if (out_valid && out_ready) begin
        cap_data.push_back(out_data);
        cap_chan.push_back(out_chan);
        cap_last.push_back(out_last);
        cap_cyc.push_back(cyc);
      end
      prev_stall <= out_valid && !out_ready;
      prev_out   <= {out_valid, out_data, out_chan, out_last};
    end
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic load(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      mem[ch][wr[ch]] = {4'(ch), 12'(nxt[ch])};
      nxt[ch]++;
      wr[ch] = wr[ch] + 8'd1;
    end
  endtask

  task automatic pulse_reset();
    #2;
    rrst = 1'b1;
    step();
    rrst = 1'b0;
  endtask

  task automatic wait_words(input int start, input int n, input int budget, input string name);
    int c;
    c = 0;
    while ((cap_data.size() - start) < n && c < budget) begin
      @(negedge rclk);
      c++;
    end
    tests++;
    if ((cap_data.size() - start) < n) begin
      fails++;
      $display("FAIL %s timeout: got %0d words, expected %0d", name, cap_data.size() - start, n);
    end
  endtask

  task automatic test_reset();
    rrst = 1'b1;
    out_ready = 1'b0;
    #3;
    tests++;
    if ({out_valid, out_last, busy, in_rinc} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b expected 0", {out_valid, out_last, busy, in_rinc});
    end
    tests++;
    if ({out_data, out_chan} !== 18'b0) begin
      fails++;
      $display("FAIL reset_data got %h expected 0", {out_data, out_chan});
    end
    step();
    rrst = 1'b0;
    out_ready = 1'b1;
    repeat (20) begin
      @(negedge rclk);
      tests++;
      if ({in_rinc, out_valid, busy} !== 6'b0) begin
        fails++;
        $display("FAIL idle_empty got %b expected 0", {in_rinc, out_valid, busy});
      end
    end
  endtask

  task automatic test_full_burst();
    int s;
    s = cap_data.size();
    step();
    load(2, 10);
    wait_words(s, 10, 60, "full_burst");
    repeat (3) step();
    for (int k = 0; k < 10; k++) begin
      tests++;
      if (cap_data[s+k] !== {4'h2, 12'(k)}) begin
        fails++;
        $display("FAIL full_burst_data[%0d] got %h expected %h", k, cap_data[s+k], {4'h2, 12'(k)});
      end
      tests++;
      if (cap_chan[s+k] !== 2'd2) begin
        fails++;
        $display("FAIL full_burst_chan[%0d] got %0d expected 2", k, cap_chan[s+k]);
      end
      tests++;
      if (cap_last[s+k] !== (k == 7)) begin
        fails++;
        $display("FAIL full_burst_last[%0d] got %b expected %b", k, cap_last[s+k], (k == 7));
      end
    end
    tests++;
    if (cap_cyc[s+8] - cap_cyc[s+7] != 2) begin
      fails++;
      $display("FAIL burst_gap got %0d cycles expected 2", cap_cyc[s+8] - cap_cyc[s+7]);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL full_burst_done busy got %b expected 0", busy);
    end
  endtask

  task automatic test_round_robin();
    int s;
    int v0;
    logic [15:0] exp_d [9];
    logic [1:0]  exp_c [9];
    exp_d = '{16'h0000, 16'h0001, 16'h0002, 16'h1000, 16'h1001, 16'h1002,
              16'h3000, 16'h3001, 16'h3002};
    exp_c = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3};
    pulse_reset();
    s  = cap_data.size();
    v0 = viol_onehot;
    load(0, 3);
    load(1, 3);
    load(3, 3);
    wait_words(s, 9, 80, "round_robin");
    repeat (3) step();
    for (int k = 0; k < 9; k++) begin
      tests++;
      if (cap_data[s+k] !== exp_d[k] || cap_chan[s+k] !== exp_c[k] || cap_last[s+k] !== 1'b0) begin
        fails++;
        $display("FAIL rr_word[%0d] got %h/ch%0d/last%b expected %h/ch%0d/last0",
                 k, cap_data[s+k], cap_chan[s+k], cap_last[s+k], exp_d[k], exp_c[k]);
      end
    end
    tests++;
    if (viol_onehot - v0 != 0) begin
      fails++;
      $display("FAIL rr_onehot got %0d multi-bit pops expected 0", viol_onehot - v0);
    end
  endtask

  task automatic test_backpressure();
    int s;
    int vs0;
    int vp0;
    int c;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    s   = cap_data.size();
    vs0 = viol_stall;
    vp0 = viol_stall_pop;
    step();
    load(1, 6);
    c = 0;
    while ((cap_data.size() - s) < 6 && c < 80) begin
      out_ready = pat[c % 4];
      step();
      c++;
    end
    out_ready = 1'b1;
    repeat (4) step();
    tests++;
    if (cap_data.size() - s != 6) begin
      fails++;
      $display("FAIL bp_count got %0d words expected 6", cap_data.size() - s);
    end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (cap_data[s+k] !== {4'h1, 12'(3 + k)} || cap_chan[s+k] !== 2'd1 || cap_last[s+k] !== 1'b0) begin
        fails++;
        $display("FAIL bp_word[%0d] got %h/ch%0d/last%b expected %h/ch1/last0",
                 k, cap_data[s+k], cap_chan[s+k], cap_last[s+k], {4'h1, 12'(3 + k)});
      end
    end
    tests++;
    if (viol_stall - vs0 != 0) begin
      fails++;
      $display("FAIL bp_stable got %0d changes while stalled expected 0", viol_stall - vs0);
    end
    tests++;
    if (viol_stall_pop - vp0 != 0) begin
      fails++;
      $display("FAIL bp_no_pop got %0d pops while stalled expected 0", viol_stall_pop - vp0);
    end
  endtask

  task automatic test_async_reset();
    int s;
    int pops;
    int c;
    logic [15:0] exp_d [8];
    logic [1:0]  exp_c [8];
    exp_d = '{16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h000A, 16'h1009, 16'h100A, 16'h3003};
    exp_c = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd3};
    step();
    load(0, 8);
    pops = 0;
    c = 0;
    while (pops < 4 && c < 60) begin
      @(negedge rclk);
      if (in_rinc[0]) pops++;
      c++;
    end
    tests++;
    if (pops != 4) begin
      fails++;
      $display("FAIL arst_reach_pop4 got %0d pops expected 4", pops);
    end
    #2;
    rrst = 1'b1;
    #1;
    tests++;
    if ({in_rinc, out_valid, busy} !== 6'b0) begin
      fails++;
      $display("FAIL arst_immediate got %b expected 0", {in_rinc, out_valid, busy});
    end
    load(1, 2);
    load(3, 1);
    step();
    step();
    rrst = 1'b0;
    s = cap_data.size();
    wait_words(s, 8, 80, "arst_drain");
    repeat (3) step();
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (cap_data[s+k] !== exp_d[k] || cap_chan[s+k] !== exp_c[k]) begin
        fails++;
        $display("FAIL arst_word[%0d] got %h/ch%0d expected %h/ch%0d",
                 k, cap_data[s+k], cap_chan[s+k], exp_d[k], exp_c[k]);
      end
    end
  endtask

`ifdef FIFO_ARB_WCOUNT_EN
  task automatic test_word_count();
    int s;
    pulse_reset();
    tests++;
    if (word_cnt !== 32'd0) begin
      fails++;
      $display("FAIL wcnt_reset got %0d expected 0", word_cnt);
    end
    s = cap_data.size();
    load(0, 10);
    load(1, 10);
    load(2, 10);
    load(3, 7);
    wait_words(s, 37, 200, "wcnt_stream");
    repeat (4) step();
    tests++;
    if (word_cnt !== 32'd37) begin
      fails++;
      $display("FAIL wcnt_total got %0d expected 37", word_cnt);
    end
  endtask
`endif

  initial begin
    rrst      = 1'b1;
    out_ready = 1'b0;
    test_reset();
    test_full_burst();
    test_round_robin();
    test_backpressure();
    test_async_reset();
`ifdef FIFO_ARB_WCOUNT_EN
    test_word_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
